// File: rtl/shift_sequencer_if.sv
// Command/result handshake bundle between a requester and shift_sequencer.
interface shift_sequencer_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic             cmd_asr;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;

  modport master (
    output cmd_valid, cmd_data, cmd_count, cmd_asr, res_ready,
    input  cmd_ready, res_valid, res_data
  );

  modport slave (
    input  cmd_valid, cmd_data, cmd_count, cmd_asr, res_ready,
    output cmd_ready, res_valid, res_data
  );
endinterface

// File: rtl/shift_sequencer.sv
// Sequences an external load/shift-right register: one load, N shifts, then result.
// Optional SHIFT_CLAMP_EN clamps the captured shift count to WIDTH.
module shift_sequencer #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  shift_sequencer_if.slave  req,
  output logic [WIDTH-1:0]  sh_load_val,
  output logic              sh_load_n,
  output logic              sh_shift,
  output logic              sh_asr,
  input  logic [WIDTH-1:0]  sh_q,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] count_in;
  logic [WIDTH-1:0] load_val_q, load_val_d;
  logic             asr_q, asr_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             load_n_q, load_n_d;
  logic             shift_q, shift_d;
  logic             res_valid_q, res_valid_d;
  logic             busy_q, busy_d;

`ifdef SHIFT_CLAMP_EN
  assign count_in = (32'(req.cmd_count) > WIDTH) ? CNT_W'(WIDTH) : req.cmd_count;
`else
  assign count_in = req.cmd_count;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_val_d = load_val_q;
    asr_d      = asr_q;
    case (state_q)
      IDLE: begin
        if (req.cmd_valid && cmd_ready_q) begin
          load_val_d = req.cmd_data;
          asr_d      = req.cmd_asr;
          cnt_d      = count_in;
          state_d    = LOAD;
        end
      end
      LOAD:  state_d = (cnt_q == '0) ? DONE : SHIFT;
      SHIFT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (req.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Control outputs are decoded from the next state so they are flops
    // that line up exactly with the state they belong to.
    cmd_ready_d = (state_d == IDLE);
    load_n_d    = (state_d != LOAD);
    shift_d     = (state_d == SHIFT);
    res_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      load_val_q  <= '0;
      asr_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      load_n_q    <= 1'b1;
      shift_q     <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      load_val_q  <= load_val_d;
      asr_q       <= asr_d;
      cmd_ready_q <= cmd_ready_d;
      load_n_q    <= load_n_d;
      shift_q     <= shift_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign sh_load_val   = load_val_q;
  assign sh_load_n     = load_n_q;
  assign sh_shift      = shift_q;
  assign sh_asr        = asr_q;
  assign busy          = busy_q;
  assign req.cmd_ready = cmd_ready_q;
  assign req.res_valid = res_valid_q;
  // The shifter holds in DONE, so passing sh_q through keeps res_data stable.
  assign req.res_data  = res_valid_q ? sh_q : '0;

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
Command-driven controller for the 8-bit load/shift-right register with arithmetic-shift option, sitting between a requester and the shifter datapath.
- Accepts one command {data, shift count, asr/lsr} over a valid/ready handshake.
- Sequences the shifter's load_n/shift/asr controls: one load cycle, then N shift cycles.
- Presents the shifter output as a result over a valid/ready handshake.
- Holds the shifter idle (load_n=1, shift=0) between commands.

Parameters:
WIDTH, 8, shifter data width; sh_load_val, sh_q, cmd_data and res_data widths.
CNT_W, 4, shift-count width; maximum count is 2^CNT_W-1.

Ports:
clock  input  1  system clock; all state updates on rising edge.
reset_n  input  1  synchronous active-low reset.
cmd_valid  input  1  requester has a command.
cmd_ready  output  1  sequencer accepts a command this cycle.
cmd_data  input  WIDTH  value to load.
cmd_count  input  CNT_W  number of right shifts.
cmd_asr  input  1  1 = arithmetic shift (fill with data MSB), 0 = logical shift (fill 0).
sh_load_val  output  WIDTH  shifter parallel-load value.
sh_load_n  output  1  shifter load, active-low.
sh_shift  output  1  shifter shift enable (effective only when sh_load_n=1).
sh_asr  output  1  shifter arithmetic-fill select.
sh_q  input  WIDTH  shifter register contents.
res_valid  output  1  result available.
res_ready  input  1  consumer takes the result.
res_data  output  WIDTH  result value.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: reset_n is synchronous, active-low, on clock.
  - State goes to IDLE.
  - Reset values: sh_load_val=0, sh_load_n=1, sh_shift=0, sh_asr=0, res_valid=0, busy=0, cmd_ready=0 during the reset cycle.
  - All control outputs are registered.
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, capture cmd_data into sh_load_val, cmd_count into the remaining-shift counter, and cmd_asr into sh_asr, then go to LOAD.
- LOAD (1 cycle):
  - sh_load_n=0, sh_shift=0. The shifter loads at the closing edge.
  - Next state is SHIFT if count!=0, else DONE.
- SHIFT:
  - sh_load_n=1, sh_shift=1, counter decrements each cycle.
  - When the counter reaches 1, the next state is DONE. Exactly count shift edges occur.
- DONE:
  - sh_load_n=1, sh_shift=0, so the shifter holds.
  - res_valid=1 and res_data=sh_q.
  - Stays in DONE until res_ready, then goes to IDLE.
  - res_data must not change while res_valid=1.
- sh_load_val and sh_asr stay stable from capture through DONE. The shifter's ASR fill bit is taken from its load value MSB, so this stability is mandatory.
- Latency: accept edge at cycle T; LOAD in T+1; SHIFT in T+2..T+1+N; res_valid first high in cycle T+2+N (T+2 for N=0).
- Throughput:
  - cmd_ready is low in LOAD, SHIFT and DONE; a command presented then is not taken.
  - Back-to-back commands have a one-cycle IDLE bubble after the result is taken.
- res_valid=0 outside DONE; res_data=0 outside DONE.
- Counts >= WIDTH are legal:
  - LSR result is 0.
  - ASR result is all copies of the data MSB.
- Reset mid-operation (any state): return to IDLE next cycle with reset values and drop any pending result. The shifter shares reset_n and clears to 0.
- cmd_* is sampled only on the accept edge; later changes are ignored.

Optional Feature:
SHIFT_CLAMP_EN
- Defined: the captured count is clamped to WIDTH (values > WIDTH become WIDTH). Results are identical; latency for large counts drops to T+2+WIDTH.
- Undefined: count is used as-is; latency is T+2+count.

Test Plan:
- LSR: cmd_data=0xB4, count=2, asr=0, accepted at T -> sh_load_n=0 in T+1, sh_shift=1 in T+2..T+3, res_valid at T+4 with res_data=0x2D.
- ASR: cmd_data=0xB4, count=3, asr=1 -> res_data=0xF6 at T+5; sh_load_val=0xB4 throughout.
- Zero count: cmd_data=0x5A, count=0 -> one LOAD cycle, no sh_shift pulse, res_data=0x5A at T+2.
- Large count with ASR: cmd_data=0x80, count=12, asr=1 -> res_data=0xFF at T+14 (T+10 with SHIFT_CLAMP_EN). Same with asr=0 -> res_data=0x00.
- Backpressure: hold res_ready=0 for 5 cycles in DONE -> res_valid and res_data stable, cmd_ready=0, a second cmd_valid is not accepted. Raise res_ready -> IDLE next cycle, second command accepted the following cycle.
- Reset mid-shift: reset_n=0 during SHIFT (count=7) -> next cycle IDLE, sh_shift=0, sh_load_n=1, res_valid=0, busy=0; cmd_ready=1 after reset_n returns high.
